// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb -- round-robin write arbiter in front of a 16-deep, 8-bit FIFO.
//
// Several requesters compete for the FIFO write port. The arbiter keeps its
// own occupancy count (occ) so that it never issues a write into a full FIFO.
// Without this count it would have to rely on the FIFO's isfull flag, which
// lags by a cycle. A requester granted on one edge is masked on the next
// edge, because its request is still held while it sees gnt.
//
// Parameters
//   NREQ  - number of write requesters (default 4)
//   DW    - data width (default 8)
//   SPACE - usable FIFO entries (default 15: depth 16, full at wrptr+1==rdptr)
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   req          in   [NREQ]     per-requester write request
//   req_data     in   [NREQ*DW]  requester i's data in [i*DW +: DW]
//   gnt          out  [NREQ]     one-hot grant, pulses for one cycle
//   fifo_wr_en   out             FIFO wr_en, high in the cycle after a grant
//   fifo_din     out  [DW]       FIFO din, holds its value between grants
//   fifo_rd_en   in              copy of the read enable presented to the FIFO
//   fifo_isempty in              FIFO isempty flag
//   occ          out  [5]        arbiter's view of FIFO occupancy
//   stall_cnt    out  [16]       saturating count of STALL cycles; present only
//                                when FIFO_ARB_STALL_CNT_EN is defined
module fifo_wr_arb #(
   parameter int NREQ  = 4,
   parameter int DW    = 8,
   parameter int SPACE = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      gnt,
   output logic                 fifo_wr_en,
   output logic [DW-1:0]        fifo_din,
   input  logic                 fifo_rd_en,
   input  logic                 fifo_isempty,
   output logic [4:0]           occ
`ifdef FIFO_ARB_STALL_CNT_EN
   ,
   output logic [15:0]          stall_cnt
`endif
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

   state_t            state_reg, state_next;
   logic [LW-1:0]     last_reg, last_next;
   logic [NREQ-1:0]   gnt_next;
   logic [DW-1:0]     din_next;
   logic [4:0]        occ_next;
   logic [DW-1:0]     data_arr [NREQ];
   logic              rd_acc;
   logic              space_ok;
   logic [NREQ-1:0]   elig;
   logic              win_found;
   logic [LW-1:0]     win_idx;

   // Unpack the flat request data bus into one word per requester.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DW +: DW];
   end

   // The write strobe is exactly "a grant was issued on the last edge".
   assign fifo_wr_en = (state_reg == GRANT);

   // A read counts only if the FIFO itself accepts it.
   assign rd_acc = fifo_rd_en && !fifo_isempty;

   // Count the write that is in flight now. Do not credit a read that
   // happens on the same edge: the decision stays conservative.
   assign space_ok = (int'(occ) + int'(fifo_wr_en)) < SPACE;

   // The requester granted last cycle still holds req while it sees gnt.
   assign elig = req & ~gnt;

   // Occupancy update, clamped to [0, SPACE].
   always_comb begin
      int occ_calc;
      occ_calc = int'(occ) + int'(fifo_wr_en) - int'(rd_acc);
      if (occ_calc < 0) begin
         occ_next = '0;
      end else if (occ_calc > SPACE) begin
         occ_next = 5'(SPACE);
      end else begin
         occ_next = 5'(occ_calc);
      end
   end

   // Round-robin search. Start just after the last winner and wrap around.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_reg) + k) % NREQ;
         if (!win_found && elig[idx]) begin
            win_found = 1'b1;
            win_idx   = LW'(idx);
         end
      end
   end

   // Next state and registered outputs.
   always_comb begin
      state_next = IDLE;
      gnt_next   = '0;
      din_next   = fifo_din;
      last_next  = last_reg;
      if (win_found) begin
         if (space_ok) begin
            state_next        = GRANT;
            gnt_next[win_idx] = 1'b1;
            din_next          = data_arr[win_idx];
            last_next         = win_idx;
         end else begin
            state_next = STALL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         last_reg  <= LW'(NREQ - 1);
         gnt       <= '0;
         fifo_din  <= '0;
         occ       <= '0;
      end else begin
         state_reg <= state_next;
         last_reg  <= last_next;
         gnt       <= gnt_next;
         fifo_din  <= din_next;
         occ       <= occ_next;
      end
   end

`ifdef FIFO_ARB_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state_reg == STALL && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed testbench for fifo_wr_arb. The bench also models the FIFO's
// entry count so that it can drive fifo_isempty and detect any write that
// is issued into a full FIFO.
module tb_fifo_wr_arb;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  gnt;
   logic        fifo_wr_en;
   logic [7:0]  fifo_din;
   logic        fifo_rd_en;
   logic        fifo_isempty;
   logic [4:0]  occ;
`ifdef FIFO_ARB_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int checks = 0;
   int failures = 0;
   int full_viol = 0;
   int wr_cnt;
   logic [4:0] env_cnt;

   fifo_wr_arb #(.NREQ(4), .DW(8), .SPACE(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_data     (req_data),
      .gnt          (gnt),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_din     (fifo_din),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_isempty (fifo_isempty),
      .occ          (occ)
`ifdef FIFO_ARB_STALL_CNT_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The FIFO's entry count. It is reset on the same edge as the arbiter.
   always @(posedge clk) begin
      if (rst) begin
         env_cnt <= '0;
      end else begin
         env_cnt <= env_cnt + {4'd0, fifo_wr_en} - {4'd0, (fifo_rd_en && env_cnt != 0)};
      end
      if (!rst && fifo_wr_en && env_cnt >= 5'd15) full_viol = full_viol + 1;
   end
   assign fifo_isempty = (env_cnt == 0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [3:0] rr_g [5];
   logic [7:0] rr_d [5];

   initial begin
      rr_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rr_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

      // Reset state
      rst = 1'b1; req = '0; fifo_rd_en = 1'b0;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11};
      tick(); tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_wr", 32'(fifo_wr_en), 32'h0);
      check("rst_din", 32'(fifo_din), 32'h0);
      check("rst_occ", 32'(occ), 32'h0);
`ifdef FIFO_ARB_STALL_CNT_EN
      check("rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif

      // All requesters held: grants go 0,1,2,3,0 on consecutive cycles
      rst = 1'b0; req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_g[i]));
         check($sformatf("rr_din%0d", i), 32'(fifo_din), 32'(rr_d[i]));
         check($sformatf("rr_wr%0d", i), 32'(fifo_wr_en), 32'h1);
      end
      check("rr_occ", 32'(occ), 32'd4);
      req = '0;
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_wr", 32'(fifo_wr_en), 32'h0);
      check("idle_din_hold", 32'(fifo_din), 32'h11);
      check("idle_occ", 32'(occ), 32'd5);

      // A single held requester is granted every other cycle
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0100; req_data[23:16] = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("alt_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h4 : 32'h0);
         if (i % 2 == 0) check($sformatf("alt_din%0d", i), 32'(fifo_din), 32'h5A);
      end
      check("alt_occ", 32'(occ), 32'd3);

      // No reads: 15 writes, then the arbiter stalls with occ=15
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b0001; wr_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (fifo_wr_en) wr_cnt++;
      end
      check("fill_writes", 32'(wr_cnt), 32'd15);
      check("fill_occ", 32'(occ), 32'd15);
      check("fill_wr", 32'(fifo_wr_en), 32'h0);
      check("fill_gnt", 32'(gnt), 32'h0);

      // One accepted read frees space; the grant comes one edge later
      fifo_rd_en = 1'b1; tick(); fifo_rd_en = 1'b0;
      check("free_occ", 32'(occ), 32'd14);
      check("free_wr", 32'(fifo_wr_en), 32'h0);
      tick();
      check("free_gnt", 32'(gnt), 32'h1);
      check("free_wr2", 32'(fifo_wr_en), 32'h1);
      check("free_occ2", 32'(occ), 32'd14);
      tick();
      check("refill_occ", 32'(occ), 32'd15);
      tick();
      check("restall_wr", 32'(fifo_wr_en), 32'h0);
      check("restall_occ", 32'(occ), 32'd15);
      check("no_wr_when_full", 32'(full_viol), 32'd0);

      // Drain to 7, then a write and a read land on the same edge
      req = '0; fifo_rd_en = 1'b1;
      repeat (8) tick();
      fifo_rd_en = 1'b0;
      check("drain_occ", 32'(occ), 32'd7);
      req = 4'b0001;
      tick();
      check("mix_wr", 32'(fifo_wr_en), 32'h1);
      fifo_rd_en = 1'b1;
      tick();
      fifo_rd_en = 1'b0; req = '0;
      check("mix_occ", 32'(occ), 32'd7);
      check("mix_wr2", 32'(fifo_wr_en), 32'h0);

      // Reset during a burst at occ=9
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      repeat (10) tick();
      check("burst_occ", 32'(occ), 32'd9);
      check("burst_gnt", 32'(gnt), 32'h2);
      rst = 1'b1; tick();
      check("mid_rst_occ", 32'(occ), 32'd0);
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_wr", 32'(fifo_wr_en), 32'h0);
`ifdef FIFO_ARB_STALL_CNT_EN
      check("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
      rst = 1'b0;
      tick();
      check("post_rst_gnt", 32'(gnt), 32'h1);
      check("post_rst_din", 32'(fifo_din), 32'h11);
      req = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst, sampled only on the rising edge of clk.
REQ-002 Parameter NREQ SHALL default to 4: the number of write requesters.
REQ-003 Parameter DW SHALL default to 8: the data width, matching the 8-bit FIFO.
REQ-004 Parameter SPACE SHALL default to 15: the usable FIFO entries (depth 16 minus one, because full means wrptr+1==rdptr).
REQ-005 Port clk SHALL be an input, 1 bit: the system clock.
REQ-006 Port rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-007 Port req SHALL be an input, NREQ bits: per-requester write request.
REQ-008 Port req_data SHALL be an input, NREQ*DW bits: requester i's data in bits [i*DW +: DW].
REQ-009 Port gnt SHALL be an output reg, NREQ bits: one-hot grant, at most one bit high.
REQ-010 Port fifo_wr_en SHALL be an output reg, 1 bit: drives the FIFO wr_en.
REQ-011 Port fifo_din SHALL be an output reg, DW bits: drives the FIFO din.
REQ-012 Port fifo_rd_en SHALL be an input, 1 bit: a copy of the read enable presented to the FIFO.
REQ-013 Port fifo_isempty SHALL be an input, 1 bit: the FIFO isempty flag.
REQ-014 Port occ SHALL be an output reg, 5 bits: the arbiter's FIFO occupancy count.

Function
REQ-015 The block SHALL count a read as accepted when fifo_rd_en && !fifo_isempty at a rising edge, matching the FIFO's own acceptance rule.
REQ-016 The block SHALL update occ on every edge as occ + fifo_wr_en - accepted_read, never wrapping below 0 or above SPACE.
REQ-017 A grant SHALL be allowed at an edge only if (occ + fifo_wr_en) < SPACE; a same-edge read SHALL NOT free space for that decision.
REQ-018 Eligible requesters at an edge SHALL be those with req[i]=1 and gnt[i]=0; the requester granted last cycle is masked so its held request is not re-granted.
REQ-019 Selection SHALL be round-robin: search starts at (last+1) mod NREQ, and last updates to the winner.
REQ-020 After reset, last SHALL be NREQ-1, so req[0] has highest priority.
REQ-021 On a grant to requester w, the next edge SHALL register gnt=one-hot(w), fifo_wr_en=1, and fifo_din=req_data[w].
REQ-022 gnt and fifo_wr_en SHALL be high for exactly one cycle per grant; with no grant they SHALL be 0, and fifo_din SHALL hold its previous value.
REQ-023 Requester protocol: hold req and req_data stable until gnt[i] is seen high, then drop req or present new data on the following edge.
REQ-024 The state machine SHALL have three states:
- IDLE: no eligible requester.
- GRANT: a grant is issued this edge.
- STALL: an eligible requester exists but the REQ-017 space check fails.
REQ-025 State transitions SHALL be evaluated every edge from the current inputs; STALL SHALL exit to GRANT on the first edge at which space exists.
REQ-026 Back-to-back grants to different requesters SHALL be allowed on consecutive edges, subject to REQ-017.
REQ-027 The block SHALL never assert fifo_wr_en when the FIFO holds SPACE entries, so the FIFO's lagging isfull is never relied upon.

Reset
REQ-028 While rst=1 at an edge, the block SHALL set gnt=0, fifo_wr_en=0, fifo_din=0, occ=0, state=IDLE, and last=NREQ-1.
REQ-029 Reset mid-operation SHALL discard any pending grant; the FIFO SHALL be reset on the same edge so that occ stays consistent with it.

Configuration
REQ-030 When macro FIFO_ARB_STALL_CNT_EN is defined, the block SHALL add output stall_cnt (16 bits), reset to 0, incremented on each edge where state is STALL and saturating at 16'hFFFF.
REQ-031 When FIFO_ARB_STALL_CNT_EN is undefined, the stall_cnt port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-032 Reset, then req=4'b1111 held -> grants in order 0,1,2,3,0 on consecutive cycles, with fifo_din following req_data.
REQ-033 Only req[2] held high with data 8'h5A -> gnt[2] pulses every other cycle, and fifo_din=8'h5A on each pulse.
REQ-034 No reads and req[0] continuously high -> exactly 15 writes, then STALL; occ=15 and fifo_wr_en stays 0.
REQ-035 From occ=15 in STALL, one accepted read -> occ=14 and the next grant follows one edge later; the FIFO never sees wr_en while full.
REQ-036 Write and accepted read on the same edge at occ=7 -> occ stays 7.
REQ-037 rst asserted during a burst with occ=9 -> occ=0, gnt=0, the next grant goes to req[0]; with FIFO_ARB_STALL_CNT_EN defined, stall_cnt=0.
